// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive buffer with first-word fall-through read port and
//            one-cycle ack handshake toward the receiver. Optional drop-on-full
//            behaviour with a sticky overflow flag: UART_RX_FIFO_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_read,
    input  logic                       out_read,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               in_read_q, in_read_d;
    logic               overflow_q, overflow_d;

    logic w_full;
    logic w_empty;
    logic w_in_req;
    logic w_push;
    logic w_pop;
    logic w_ack;

    assign w_full   = (count_q == c_full_cnt);
    assign w_empty  = (count_q == '0);
    // The receiver keeps valid high through the ack cycle, so it is blanked there.
    assign w_in_req = in_valid && !in_read_q;
    assign w_push   = w_in_req && !w_full;
    assign w_pop    = out_read && !w_empty;

`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic w_drop;
    assign w_ack  = w_in_req;
    assign w_drop = w_in_req && w_full;

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end else if (w_drop) begin
            overflow_d = 1'b1;
        end
    end
`else
    logic w_unused_clr;
    assign w_ack        = w_push;
    assign w_unused_clr = clr_overflow;
    assign overflow_d   = 1'b0;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        in_read_d = w_ack;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_read_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_read_q  <= in_read_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_read   = in_read_q;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo (DEPTH=8, DATA_W=8); honours
//            UART_RX_FIFO_OVERFLOW_EN for the full-FIFO scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_read;
    logic              out_read;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [3:0]        count;
    logic              overflow;
    logic              clr_overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_read      (in_read),
        .out_read     (out_read),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       pop;
        logic       exp_read;
        logic [3:0] exp_count;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver model: hold valid until acked, keep it through the ack cycle.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        tick();
        while (!in_read && waited < 50) begin
            tick();
            waited++;
        end
        chk("send_ack", int'(in_read), 1);
        if (sb_q.size() < DEPTH) sb_q.push_back(b);
        chk("send_count", int'(count), sb_q.size());
        tick();
        chk("blank_no_repush", int'(in_read), 0);
        chk("blank_count", int'(count), sb_q.size());
        in_valid = 1'b0;
    endtask

    task automatic pop_check();
        logic [7:0] exp;
        exp = sb_q.pop_front();
        chk("pop_data", int'(out_data), int'(exp));
        chk("pop_valid", int'(out_valid), 1);
        out_read = 1'b1;
        tick();
        out_read = 1'b0;
        chk("pop_count", int'(count), sb_q.size());
    endtask

    task automatic drain();
        while (sb_q.size() > 0) pop_check();
        chk("drain_out_zero", int'(out_data), 0);
        chk("drain_valid", int'(out_valid), 0);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        out_read     = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_in_read", int'(in_read), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Single-byte handshake, pop on empty, push+pop corner cases.
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 4'd1, 8'h41};
        vecs[1] = '{1'b1, 8'h41, 1'b0, 1'b0, 4'd1, 8'h41};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00};
        vecs[4] = '{1'b1, 8'h66, 1'b1, 1'b1, 4'd1, 8'h66};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 8'h66};
        vecs[6] = '{1'b1, 8'h55, 1'b0, 1'b1, 4'd2, 8'h66};
        vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 4'd1, 8'h55};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00};
        for (int i = 0; i < 9; i++) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            out_read = vecs[i].pop;
            tick();
            chk($sformatf("vec%0d_in_read", i), int'(in_read), int'(vecs[i].exp_read));
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
            chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].exp_out));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid),
                (vecs[i].exp_count != 0) ? 1 : 0);
        end
        in_valid = 1'b0;
        out_read = 1'b0;

        // Fill and drain twice so both pointers wrap.
        for (int r = 0; r < 2; r++) begin
            for (int b = 1; b <= DEPTH; b++) send_byte(8'(r * DEPTH + b));
            chk("fill_full", int'(count), DEPTH);
            drain();
        end

        // Full FIFO with a pending byte.
        for (int b = 0; b < DEPTH; b++) send_byte(8'h20 + 8'(b));
        in_valid = 1'b1;
        in_data  = 8'h99;
`ifdef UART_RX_FIFO_OVERFLOW_EN
        tick();
        chk("ovf_ack", int'(in_read), 1);
        chk("ovf_count", int'(count), DEPTH);
        chk("ovf_set", int'(overflow), 1);
        tick();
        in_valid = 1'b0;
        chk("ovf_sticky", int'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clear", int'(overflow), 0);
        in_valid     = 1'b1;
        in_data      = 8'h98;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr_prio_ack", int'(in_read), 1);
        chk("ovf_clr_prio", int'(overflow), 0);
        tick();
        in_valid = 1'b0;
        chk("ovf_clr_prio_hold", int'(overflow), 0);
        drain();
`else
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_no_ack", int'(in_read), 0);
            chk("stall_count", int'(count), DEPTH);
        end
        pop_check();
        chk("stall_no_push_on_pop", int'(in_read), 0);
        tick();
        chk("stall_late_ack", int'(in_read), 1);
        chk("stall_refull", int'(count), DEPTH);
        sb_q.push_back(8'h99);
        tick();
        in_valid = 1'b0;
        chk("stall_overflow_zero", int'(overflow), 0);
        drain();
`endif

        // count=3, simultaneous push 0x55 and pop.
        for (int b = 0; b < 3; b++) send_byte(8'hA0 + 8'(b));
        chk("pp_head", int'(out_data), int'(sb_q[0]));
        void'(sb_q.pop_front());
        out_read = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        out_read = 1'b0;
        chk("pp_ack", int'(in_read), 1);
        chk("pp_count", int'(count), 3);
        sb_q.push_back(8'h55);
        tick();
        in_valid = 1'b0;
        drain();

        // Reset landing in an ack cycle with count=5.
        for (int b = 0; b < 4; b++) send_byte(8'hC0 + 8'(b));
        in_valid = 1'b1;
        in_data  = 8'hC4;
        tick();
        chk("pre_rst_ack", int'(in_read), 1);
        chk("pre_rst_count", int'(count), 5);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_in_read", int'(in_read), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
